// File: rtl/rsg_pkg.sv
// Shared definitions for the READY->SET->GO sequencer: state encoding and
// the helper that turns a zero length into a one-cycle dwell.
package rsg_pkg;

    typedef enum logic [1:0] {
        READY = 2'b00,
        SET   = 2'b01,
        GO    = 2'b10,
        DONE  = 2'b11
    } rsg_state_e;

    localparam int MAX_CNT_W = 16;

    function automatic logic [MAX_CNT_W-1:0] len_at_least_one(input logic [MAX_CNT_W-1:0] len);
        return (len == '0) ? MAX_CNT_W'(1) : len;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter for phase dwell times; load beats decrement and the
// count parks at zero instead of wrapping.
module dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rsg_sequencer.sv
// READY->SET->GO->DONE sequencer with programmable SET and GO dwell lengths.
//   state | meaning
//   READY | idle, waiting for start
//   SET   | SET dwell running, busy
//   GO    | GO window open, busy
//   DONE  | single-cycle completion pulse
module rsg_sequencer
    import rsg_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] set_len,
    input  logic [CNT_W-1:0] go_len,
    output logic [1:0]       state,
    output logic             busy,
    output logic             go,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    rsg_state_e       state_q, state_d;
    logic [CNT_W-1:0] set_lat, go_lat, set_lat_d, go_lat_d;
    logic [CNT_W-1:0] load_val;
    logic             load, dec, zero, accept;

    dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .cnt      (cnt),
        .zero     (zero)
    );

    always_comb begin
        state_d   = state_q;
        set_lat_d = set_lat;
        go_lat_d  = go_lat;
        load      = 1'b0;
        load_val  = '0;
        dec       = 1'b0;
        accept    = 1'b0;
        if (abort) begin
            state_d = READY;
            load    = 1'b1;
        end else begin
            case (state_q)
                READY: accept = start;
                SET: begin
                    if (zero) begin
                        state_d  = GO;
                        load     = 1'b1;
                        load_val = go_lat - CNT_W'(1);
                    end else begin
                        dec = 1'b1;
                    end
                end
                GO: begin
                    if (zero) begin
                        state_d = DONE;
                        load    = 1'b1;
                    end else begin
                        dec = 1'b1;
                    end
                end
                DONE: begin
                    state_d = READY;
                    accept  = AUTO_RESTART && start;
                end
                default: begin
                    state_d = READY;
                    load    = 1'b1;
                end
            endcase
        end
        // The SET dwell is loaded from the freshly latched length in the same cycle.
        if (accept) begin
            set_lat_d = CNT_W'(len_at_least_one(MAX_CNT_W'(set_len)));
            go_lat_d  = CNT_W'(len_at_least_one(MAX_CNT_W'(go_len)));
            state_d   = SET;
            load      = 1'b1;
            load_val  = set_lat_d - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= READY;
            set_lat <= '0;
            go_lat  <= '0;
            busy    <= 1'b0;
            go      <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            set_lat <= set_lat_d;
            go_lat  <= go_lat_d;
            busy    <= (state_d == SET) || (state_d == GO);
            go      <= (state_d == GO);
            done    <= (state_d == DONE);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_rsg_sequencer.sv
// Self-checking bench for rsg_sequencer: directed vector table, hand-written
// corner sequences and random traffic against a phase/remaining-cycles model.
module tb_rsg_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] set_len = '0;
    logic [7:0] go_len = '0;

    logic [1:0] st0, st1;
    logic       busy0, busy1, go0, go1, done0, done1;
    logic [7:0] cnt0, cnt1;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    rsg_sequencer #(.CNT_W(8), .AUTO_RESTART(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .set_len(set_len), .go_len(go_len),
        .state(st0), .busy(busy0), .go(go0), .done(done0), .cnt(cnt0)
    );

    rsg_sequencer #(.CNT_W(8), .AUTO_RESTART(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .set_len(set_len), .go_len(go_len),
        .state(st1), .busy(busy1), .go(go1), .done(done1), .cnt(cnt1)
    );

    // Reference model: phase 0..3 = READY/SET/GO/DONE, rem = cycles left in phase.
    typedef struct {
        int phase;
        int rem;
        int s;
        int g;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mdl_step(mdl_t m, bit ar, bit st, bit ab, int sl, int gl);
        mdl_t n = m;
        bit acc = 1'b0;
        if (ab) begin
            n.phase = 0;
            n.rem   = 0;
            return n;
        end
        case (m.phase)
            0: acc = st;
            1: begin
                n.rem = m.rem - 1;
                if (n.rem == 0) begin
                    n.phase = 2;
                    n.rem   = m.g;
                end
            end
            2: begin
                n.rem = m.rem - 1;
                if (n.rem == 0) n.phase = 3;
            end
            default: begin
                n.phase = 0;
                acc = ar && st;
            end
        endcase
        if (acc) begin
            n.s     = (sl == 0) ? 1 : sl;
            n.g     = (gl == 0) ? 1 : gl;
            n.phase = 1;
            n.rem   = n.s;
        end
        return n;
    endfunction

    function automatic logic [12:0] mdl_out(mdl_t m);
        logic [1:0] s2;
        int c;
        s2 = 2'(m.phase);
        c  = (m.phase == 1 || m.phase == 2) ? m.rem - 1 : 0;
        return {s2, (m.phase == 1 || m.phase == 2), (m.phase == 2), (m.phase == 3), 8'(c)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= '{0, 0, 0, 0};
            m1 <= '{0, 0, 0, 0};
        end else begin
            m0 <= mdl_step(m0, 1'b0, start, abort, int'(set_len), int'(go_len));
            m1 <= mdl_step(m1, 1'b1, start, abort, int'(set_len), int'(go_len));
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_models();
        chk("model_ar0", {3'b0, st0, busy0, go0, done0, cnt0}, {3'b0, mdl_out(m0)});
        chk("model_ar1", {3'b0, st1, busy1, go1, done1, cnt1}, {3'b0, mdl_out(m1)});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_models();
    endtask

    typedef struct {
        bit         start;
        bit         abort;
        logic [7:0] sl;
        logic [7:0] gl;
        logic [1:0] st;
        bit         go;
        bit         done;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    logic [1:0] seq0[8];
    logic [1:0] seq1[8];
    logic [1:0] exp_seq0[8] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b01, 2'b10};
    logic [1:0] exp_seq1[8] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b01, 2'b01, 2'b10, 2'b11};

    initial begin
        // basic sequence S=3, G=2
        tbl.push_back('{1'b1, 1'b0, 8'd3, 8'd2, 2'b01, 1'b0, 1'b0, 8'd2});
        tbl.push_back('{1'b0, 1'b0, 8'd3, 8'd2, 2'b01, 1'b0, 1'b0, 8'd1});
        tbl.push_back('{1'b0, 1'b0, 8'd3, 8'd2, 2'b01, 1'b0, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 8'd3, 8'd2, 2'b10, 1'b1, 1'b0, 8'd1});
        tbl.push_back('{1'b0, 1'b0, 8'd3, 8'd2, 2'b10, 1'b1, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 8'd3, 8'd2, 2'b11, 1'b0, 1'b1, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 8'd3, 8'd2, 2'b00, 1'b0, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 8'd3, 8'd2, 2'b00, 1'b0, 1'b0, 8'd0});
        // zero lengths behave as one
        tbl.push_back('{1'b1, 1'b0, 8'd0, 8'd0, 2'b01, 1'b0, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 8'd0, 8'd0, 2'b10, 1'b1, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 8'd0, 8'd0, 2'b11, 1'b0, 1'b1, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0, 8'd0});
        // start with abort in READY is refused
        tbl.push_back('{1'b1, 1'b1, 8'd5, 8'd5, 2'b00, 1'b0, 1'b0, 8'd0});
        // start held and set_len changed mid-sequence have no effect
        tbl.push_back('{1'b1, 1'b0, 8'd2, 8'd1, 2'b01, 1'b0, 1'b0, 8'd1});
        tbl.push_back('{1'b1, 1'b0, 8'd7, 8'd1, 2'b01, 1'b0, 1'b0, 8'd0});
        tbl.push_back('{1'b1, 1'b0, 8'd7, 8'd1, 2'b10, 1'b1, 1'b0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 8'd7, 8'd1, 2'b11, 1'b0, 1'b1, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 8'd7, 8'd1, 2'b00, 1'b0, 1'b0, 8'd0});

        repeat (2) @(negedge clk);
        chk("reset_dut0", {3'b0, st0, busy0, go0, done0, cnt0}, 16'h0);
        chk("reset_dut1", {3'b0, st1, busy1, go1, done1, cnt1}, 16'h0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            start   = tbl[i].start;
            abort   = tbl[i].abort;
            set_len = tbl[i].sl;
            go_len  = tbl[i].gl;
            step();
            chk($sformatf("vec%0d", i), {3'b0, st0, busy0, go0, done0, cnt0},
                {3'b0, tbl[i].st, (tbl[i].st == 2'b01 || tbl[i].st == 2'b10),
                 tbl[i].go, tbl[i].done, tbl[i].cnt});
        end

        // abort during GO when cnt reaches 4
        start = 1'b1; abort = 1'b0; set_len = 8'd1; go_len = 8'd8;
        step();
        start = 1'b0;
        step();
        begin
            bit found = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (st0 == 2'b10 && cnt0 == 8'd4) begin
                    found = 1'b1;
                    break;
                end
                step();
            end
            chk("abort_reach_cnt4", {15'b0, found}, 16'h1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_go", {3'b0, st0, busy0, go0, done0, cnt0}, 16'h0);
        step();

        // held start: auto-restart has no READY gap, plain version inserts one
        start = 1'b1; set_len = 8'd2; go_len = 8'd1;
        for (int k = 0; k < 8; k++) begin
            step();
            seq0[k] = st0;
            seq1[k] = st1;
        end
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("restart0_%0d", k), {14'b0, seq0[k]}, {14'b0, exp_seq0[k]});
            chk($sformatf("restart1_%0d", k), {14'b0, seq1[k]}, {14'b0, exp_seq1[k]});
        end
        start = 1'b0;
        repeat (5) step();

        // asynchronous reset in the middle of SET
        start = 1'b1; set_len = 8'd5; go_len = 8'd1;
        step();
        start = 1'b0;
        step();
        chk("pre_reset_set", {14'b0, st0}, 16'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_dut0", {3'b0, st0, busy0, go0, done0, cnt0}, 16'h0);
        chk("async_rst_dut1", {3'b0, st1, busy1, go1, done1, cnt1}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; set_len = 8'd1; go_len = 8'd1;
        step();
        chk("first_start_after_rst", {14'b0, st0}, 16'h1);
        start = 1'b0;
        repeat (4) step();

        // random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            start   = 1'($urandom_range(0, 1));
            abort   = ($urandom_range(0, 15) == 0);
            set_len = 8'($urandom_range(0, 5));
            go_len  = 8'($urandom_range(0, 5));
            step();
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", npass, ntotal);
        $fatal(1);
    end

endmodule
